// File: rtl/wb_pio_ctrl.sv
// Wishbone-slave parallel I/O controller: per-channel output/OE, synchronised inputs,
// atomic set/clear/toggle and edge interrupts. Optional input debounce via PIO_DEBOUNCE_EN.
module wb_pio_ctrl #(
   parameter int          ADDRWIDTH      = 7,
   parameter int          NUM_PIO        = 8,
   parameter int          SYNC_STAGES    = 2,
   parameter logic [31:0] PIO_ID_VALUE   = 32'h0010_A010,
   parameter logic [31:0] DEF_REG_VALUE  = 32'hFAB_DEF_AC,
   parameter int          DEBOUNCE_WIDTH = 4
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST,
   input  logic [ADDRWIDTH-1:0] WBs_ADR,
   input  logic                 WBs_CYC,
   input  logic                 WBs_STB,
   input  logic                 WBs_WE,
   input  logic [3:0]           WBs_BYTE_STB,
   input  logic [31:0]          WBs_WR_DAT,
   output logic [31:0]          WBs_RD_DAT,
   output logic                 WBs_ACK,
   input  logic [NUM_PIO-1:0]   pio_i,
   output logic [NUM_PIO-1:0]   pio_o,
   output logic [NUM_PIO-1:0]   pio_oe,
   output logic                 Interrupt_o
);

   localparam logic [ADDRWIDTH-1:0] ADR_ID   = ADDRWIDTH'(0);
   localparam logic [ADDRWIDTH-1:0] ADR_OUT  = ADDRWIDTH'(1);
   localparam logic [ADDRWIDTH-1:0] ADR_OE   = ADDRWIDTH'(2);
   localparam logic [ADDRWIDTH-1:0] ADR_IN   = ADDRWIDTH'(3);
   localparam logic [ADDRWIDTH-1:0] ADR_SET  = ADDRWIDTH'(4);
   localparam logic [ADDRWIDTH-1:0] ADR_CLR  = ADDRWIDTH'(5);
   localparam logic [ADDRWIDTH-1:0] ADR_TGL  = ADDRWIDTH'(6);
   localparam logic [ADDRWIDTH-1:0] ADR_RISE = ADDRWIDTH'(7);
   localparam logic [ADDRWIDTH-1:0] ADR_FALL = ADDRWIDTH'(8);
   localparam logic [ADDRWIDTH-1:0] ADR_STAT = ADDRWIDTH'(9);
   localparam logic [ADDRWIDTH-1:0] ADR_PEND = ADDRWIDTH'(10);

`ifdef PIO_DEBOUNCE_EN
   localparam int SUP_LEN = SYNC_STAGES + 1 + (1 << DEBOUNCE_WIDTH) - 1;
`else
   localparam int SUP_LEN = SYNC_STAGES + 1;
`endif
   localparam int SUP_W = $clog2(SUP_LEN + 1);

   logic               req, rd_req, wr_req;
   logic [NUM_PIO-1:0] wmask, wdat, w1c;
   logic [NUM_PIO-1:0] out_reg, oe_reg, rise_en, fall_en, irq_stat, irq_pend;
   logic [NUM_PIO-1:0] sync_q [SYNC_STAGES];
   logic [NUM_PIO-1:0] sync_s, filt, prev, rise, fall, set_ev;
   logic [SUP_W-1:0]   sup_cnt;
   logic               edge_ok;
   logic [31:0]        rd_mux;
   logic               unused_ok;

   function automatic logic [31:0] ext(input logic [NUM_PIO-1:0] v);
      ext = '0;
      ext[NUM_PIO-1:0] = v;
   endfunction

   assign req    = WBs_CYC & WBs_STB & ~WBs_ACK;
   assign rd_req = req & ~WBs_WE;
   assign wr_req = req & WBs_WE;

   assign unused_ok = &{1'b0, WBs_WR_DAT, WBs_BYTE_STB, (DEBOUNCE_WIDTH > 0)};

   // Write data with byte lanes applied; bits at and above NUM_PIO never reach a register
   always_comb begin
      wmask = '0;
      wdat  = '0;
      for (int i = 0; i < NUM_PIO; i++) begin
         wmask[i] = WBs_BYTE_STB[i >> 3];
         wdat[i]  = WBs_WR_DAT[i] & WBs_BYTE_STB[i >> 3];
      end
   end

   assign w1c      = (wr_req && (WBs_ADR == ADR_STAT)) ? wdat : '0;
   assign irq_pend = irq_stat & (rise_en | fall_en);
   assign sync_s   = sync_q[SYNC_STAGES-1];
   assign edge_ok  = (sup_cnt == SUP_W'(SUP_LEN));
   assign rise     = filt & ~prev;
   assign fall     = ~filt & prev;
   assign set_ev   = edge_ok ? ((rise & rise_en) | (fall & fall_en)) : '0;
   assign pio_o    = out_reg;
   assign pio_oe   = oe_reg;

   always_comb begin
      rd_mux = DEF_REG_VALUE;
      case (WBs_ADR)
         ADR_ID:   rd_mux = PIO_ID_VALUE;
         ADR_OUT:  rd_mux = ext(out_reg);
         ADR_OE:   rd_mux = ext(oe_reg);
         ADR_IN:   rd_mux = ext(filt);
         ADR_SET, ADR_CLR, ADR_TGL: rd_mux = '0;
         ADR_RISE: rd_mux = ext(rise_en);
         ADR_FALL: rd_mux = ext(fall_en);
         ADR_STAT: rd_mux = ext(irq_stat);
         ADR_PEND: rd_mux = ext(irq_pend);
         default:  rd_mux = DEF_REG_VALUE;
      endcase
   end

   // Input synchroniser; edges are ignored until the pipeline has refilled after reset
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         prev    <= '0;
         sup_cnt <= '0;
      end else begin
         sync_q[0] <= pio_i;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         prev <= filt;
         if (!edge_ok) sup_cnt <= sup_cnt + 1'b1;
      end
   end

`ifdef PIO_DEBOUNCE_EN
   localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST = DEBOUNCE_WIDTH'((1 << DEBOUNCE_WIDTH) - 2);
   logic [DEBOUNCE_WIDTH-1:0] db_cnt [NUM_PIO];

   // Filtered value follows only after 2^W-1 consecutive disagreeing samples
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         filt <= '0;
         for (int i = 0; i < NUM_PIO; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_PIO; i++) begin
            if (sync_s[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               filt[i]   <= sync_s[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign filt = sync_s;
`endif

   // Bus side: single-cycle ACK, register writes, and sticky interrupt status where a new edge beats W1C
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         WBs_ACK     <= 1'b0;
         WBs_RD_DAT  <= '0;
         out_reg     <= '0;
         oe_reg      <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         irq_stat    <= '0;
         Interrupt_o <= 1'b0;
      end else begin
         WBs_ACK <= req;
         if (rd_req) WBs_RD_DAT <= rd_mux;
         if (wr_req) begin
            case (WBs_ADR)
               ADR_OUT:  out_reg <= (out_reg & ~wmask) | wdat;
               ADR_OE:   oe_reg  <= (oe_reg & ~wmask) | wdat;
               ADR_SET:  out_reg <= out_reg | wdat;
               ADR_CLR:  out_reg <= out_reg & ~wdat;
               ADR_TGL:  out_reg <= out_reg ^ wdat;
               ADR_RISE: rise_en <= (rise_en & ~wmask) | wdat;
               ADR_FALL: fall_en <= (fall_en & ~wmask) | wdat;
               default:  ;
            endcase
         end
         irq_stat    <= (irq_stat & ~w1c) | set_ev;
         Interrupt_o <= |irq_pend;
      end
   end

endmodule

// File: doc/wb_pio_ctrl.md
Name: wb_pio_ctrl

Overview:
- Wishbone-slave parallel I/O controller for the AL4S3B fabric.
- Generalises the fixed LED outputs to NUM_PIO channels, each with:
  - output drive and per-channel output enable;
  - synchronised input sampling;
  - atomic set/clear/toggle registers;
  - per-channel rising/falling edge interrupts.
- Sits beside the fabric register block on the WB_CLK domain.
- Its Interrupt_o feeds FB_msg_out[0].

Parameters:
- ADDRWIDTH, 7: word-address width of WBs_ADR.
- NUM_PIO, 8: number of channels, legal range 1..32.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.
- PIO_ID_VALUE, 32'h0010_A010: value returned by the ID register.
- DEF_REG_VALUE, 32'hFAB_DEF_AC: read value for unmapped addresses.
- DEBOUNCE_WIDTH, 4: debounce counter width; used only with PIO_DEBOUNCE_EN.

Ports:
- WB_CLK  in  1  sole clock.
- WB_RST  in  1  synchronous, active-high reset.
- WBs_ADR  in  ADDRWIDTH  register word index.
- WBs_CYC  in  1  cycle/chip select.
- WBs_STB  in  1  transfer strobe.
- WBs_WE  in  1  write enable.
- WBs_BYTE_STB  in  4  byte enables.
- WBs_WR_DAT  in  32  write data.
- WBs_RD_DAT  out  32  registered read data.
- WBs_ACK  out  1  transfer acknowledge.
- pio_i  in  NUM_PIO  asynchronous pad inputs.
- pio_o  out  NUM_PIO  output data.
- pio_oe  out  NUM_PIO  output enables (1 = drive).
- Interrupt_o  out  1  level interrupt.

Behaviour:
- Clocking and reset (already decided): one clock, WB_CLK; reset WB_RST is synchronous and active-high.
- Reset values, all outputs and registers 0:
  - WBs_ACK, WBs_RD_DAT, pio_o, pio_oe, Interrupt_o;
  - synchronisers, RISE_EN, FALL_EN, IRQ_STAT.
- Bus handshake:
  - req = WBs_CYC & WBs_STB & ~WBs_ACK.
  - On an edge with req=1: WBs_ACK <= 1 for exactly one cycle. Reads load WBs_RD_DAT on that edge; writes commit on that edge.
  - Latency is 1 cycle. Back-to-back requests ACK every other cycle.
  - WB_RST asserted during a pending request: ACK is forced 0 and the write is discarded.
- Byte lanes: every write honours WBs_BYTE_STB per byte, including the SET/CLR/TGL masks.
- Width rule: bits [31:NUM_PIO] read 0 and are ignored on write.
- Register map (word index):
  - 0 ID, RO: PIO_ID_VALUE.
  - 1 OUT, RW: drives pio_o.
  - 2 OE, RW: drives pio_oe.
  - 3 IN, RO: synchronised (or debounced) input.
  - 4 OUT_SET, WO: OUT |= data; reads 0.
  - 5 OUT_CLR, WO: OUT &= ~data; reads 0.
  - 6 OUT_TGL, WO: OUT ^= data; reads 0.
  - 7 RISE_EN, RW.
  - 8 FALL_EN, RW.
  - 9 IRQ_STAT, RW1C.
  - 10 IRQ_PEND, RO: IRQ_STAT & (RISE_EN | FALL_EN).
  - Other indices: read DEF_REG_VALUE; writes ignored.
- Output timing: pio_o and pio_oe update on the commit edge and are visible the cycle after ACK rises.
- Input path:
  - SYNC_STAGES flops, then a prev register.
  - IN reflects a pio_i change SYNC_STAGES edges later.
- Edge detection:
  - rise = s & ~prev; fall = ~s & prev.
  - IRQ_STAT[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]), i.e. SYNC_STAGES+1 edges after the pio_i change.
  - Edge detection is suppressed for SYNC_STAGES+1 cycles after reset release, so pins held high at reset produce no spurious edge.
- IRQ_STAT priority: a W1C write and a new edge on the same bit in the same cycle leave the bit set (set wins). Disabling an enable does not clear a stat bit already set.
- Interrupt_o = |IRQ_PEND, registered, so it rises 1 cycle after the IRQ_STAT bit.

Optional Feature:
- Macro: PIO_DEBOUNCE_EN.
- Defined:
  - Per-channel DEBOUNCE_WIDTH-bit counter after the synchroniser.
  - The filtered value changes only after the synchronised input differs from it for 2^DEBOUNCE_WIDTH-1 consecutive cycles; the counter clears on any agreement.
  - IN and edge detection use the filtered value.
  - Debounce counters reset to 0.
- Undefined: no counters; DEBOUNCE_WIDTH is unused; latency is as above.

Test Plan:
- Read index 0 after reset -> WBs_RD_DAT=32'h0010_A010, with ACK high exactly 1 cycle; read index 15 -> 32'hFAB_DEF_AC.
- Sequence: write OUT=0xA5, then OUT_SET=0x0F, OUT_CLR=0x80, OUT_TGL=0x03 -> pio_o reads 0xA5, 0xAF, 0x2F, 0x2C. Write OE=0xFF with BYTE_STB=4'b0000 -> OE stays 0.
- RISE_EN=0x01; pio_i[0] 0->1 -> IRQ_STAT=0x01 after 3 edges (SYNC_STAGES=2) and Interrupt_o=1 one cycle later. W1C 0x01 -> Interrupt_o=0. A falling edge with FALL_EN=0 -> no interrupt.
- W1C write of IRQ_STAT bit 0 on the same edge as a new rising edge on pio_i[0] -> bit remains 1 and Interrupt_o stays 1.
- pio_i=0xFF held through reset -> no IRQ_STAT bits set after reset; IN=0xFF after 2 cycles. WB_RST pulsed mid-write to OUT -> no ACK, OUT=0.
- With PIO_DEBOUNCE_EN and DEBOUNCE_WIDTH=4: a 10-cycle glitch -> IN unchanged; a 15-cycle stable level -> IN updates.
